// File: rtl/giu_ecc_err_reporter.sv
// giu_ecc_err_reporter
// Collects single-bit (correctable) and double-bit (uncorrectable) ECC error
// pulses from two memories and turns them into saturating statistics,
// a correctable-error threshold monitor, sticky interrupts and sticky faults.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   mem{0,1}_sbe / mem{0,1}_dbe per-memory single/double-bit error pulses
//   irq_c_en, irq_uc_en         interrupt enables
//   irq_c_clr, irq_uc_clr       interrupt clear pulses
//   cnt_clr                     clears the four per-memory counters
//   cerr_clr                    clears the correctable counter and threshold flag
//   cerr_threshold              correctable threshold, 0 disables the monitor
//   single_bit_count{0,1}       per-memory corrected error counts
//   double_bit_count{0,1}       per-memory uncorrectable error counts
//   cerr_counter                total correctable events from both memories
//   cerr_over_thres_fault       high while the threshold monitor is tripped
//   IRQ_C, IRQ_UC               sticky interrupts
//   fault_mission_fault         sticky, set by any double-bit error
//   fault_latent_fault          sticky, set when the threshold monitor trips
module giu_ecc_err_reporter #(
  parameter int CNT_W   = 32,
  parameter int CERR_W  = 16,
  parameter int THRES_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem0_sbe,
  input  logic               mem0_dbe,
  input  logic               mem1_sbe,
  input  logic               mem1_dbe,
  input  logic               irq_c_en,
  input  logic               irq_uc_en,
  input  logic               irq_c_clr,
  input  logic               irq_uc_clr,
  input  logic               cnt_clr,
  input  logic               cerr_clr,
  input  logic [THRES_W-1:0] cerr_threshold,
  output logic [CNT_W-1:0]   single_bit_count0,
  output logic [CNT_W-1:0]   single_bit_count1,
  output logic [CNT_W-1:0]   double_bit_count0,
  output logic [CNT_W-1:0]   double_bit_count1,
  output logic [CERR_W-1:0]  cerr_counter,
  output logic               cerr_over_thres_fault,
  output logic               IRQ_C,
  output logic               IRQ_UC,
  output logic               fault_mission_fault,
  output logic               fault_latent_fault
);

  localparam int CMP_W = (CERR_W > THRES_W) ? CERR_W : THRES_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    OVER  = 2'd2
  } cerrState_e;

  cerrState_e state_q, state_d;

  logic [CNT_W-1:0]  sbc0_q, sbc0_d, sbc1_q, sbc1_d;
  logic [CNT_W-1:0]  dbc0_q, dbc0_d, dbc1_q, dbc1_d;
  logic [CERR_W-1:0] cerr_q, cerr_d;
  logic              irqC_q, irqC_d, irqUc_q, irqUc_d;
  logic              mission_q, mission_d, latent_q, latent_d;

  logic              qSbe0, qSbe1, anySbe, anyDbe;
  logic [1:0]        sbeNum;
  logic [CERR_W:0]   cerrSum;
  logic [CERR_W-1:0] cerrSat;
  logic              thresHit;

  // A double-bit error on a memory hides any single-bit report from it in the same cycle.
  assign qSbe0  = mem0_sbe & ~mem0_dbe;
  assign qSbe1  = mem1_sbe & ~mem1_dbe;
  assign anySbe = qSbe0 | qSbe1;
  assign anyDbe = mem0_dbe | mem1_dbe;
  assign sbeNum = {1'b0, qSbe0} + {1'b0, qSbe1};

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic ev);
    if (ev && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  // Per-memory statistics: saturating, and a clear discards same-cycle events.
  always_comb begin
    sbc0_d = cnt_clr ? '0 : satInc(sbc0_q, qSbe0);
    sbc1_d = cnt_clr ? '0 : satInc(sbc1_q, qSbe1);
    dbc0_d = cnt_clr ? '0 : satInc(dbc0_q, mem0_dbe);
    dbc1_d = cnt_clr ? '0 : satInc(dbc1_q, mem1_dbe);
  end

  // Correctable total: one extra bit catches the carry so a +2 step from
  // all-ones-minus-one still lands exactly on all-ones. The threshold compare
  // looks at the value the counter is about to take, so a lowered threshold
  // trips the monitor even when no new event arrives.
  always_comb begin
    cerrSum  = {1'b0, cerr_q} + (CERR_W+1)'(sbeNum);
    cerrSat  = cerrSum[CERR_W] ? '1 : cerrSum[CERR_W-1:0];
    cerr_d   = cerr_clr ? '0 : cerrSat;
    thresHit = (cerr_threshold != '0) && (CMP_W'(cerrSat) >= CMP_W'(cerr_threshold));
  end

  // Threshold monitor next state; OVER is only left through cerr_clr or reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cerr_clr)      state_d = IDLE;
        else if (thresHit) state_d = OVER;
        else if (anySbe)   state_d = COUNT;
      end
      COUNT: begin
        if (cerr_clr)      state_d = IDLE;
        else if (thresHit) state_d = OVER;
      end
      OVER: begin
        if (cerr_clr)      state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags: an interrupt set beats its own clear so no event is lost.
  always_comb begin
    irqC_d    = (anySbe & irq_c_en) ? 1'b1 : (irq_c_clr ? 1'b0 : irqC_q);
    irqUc_d   = (anyDbe & irq_uc_en) ? 1'b1 : (irq_uc_clr ? 1'b0 : irqUc_q);
    mission_d = mission_q | anyDbe;
    latent_d  = latent_q | ((state_d == OVER) && (state_q != OVER));
  end

  // All state, with reset dominating any activity on the inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sbc0_q    <= '0;
      sbc1_q    <= '0;
      dbc0_q    <= '0;
      dbc1_q    <= '0;
      cerr_q    <= '0;
      irqC_q    <= 1'b0;
      irqUc_q   <= 1'b0;
      mission_q <= 1'b0;
      latent_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sbc0_q    <= sbc0_d;
      sbc1_q    <= sbc1_d;
      dbc0_q    <= dbc0_d;
      dbc1_q    <= dbc1_d;
      cerr_q    <= cerr_d;
      irqC_q    <= irqC_d;
      irqUc_q   <= irqUc_d;
      mission_q <= mission_d;
      latent_q  <= latent_d;
    end
  end

  // Outputs come straight from flops; the fault flag is a decode of the state register.
  always_comb begin
    single_bit_count0     = sbc0_q;
    single_bit_count1     = sbc1_q;
    double_bit_count0     = dbc0_q;
    double_bit_count1     = dbc1_q;
    cerr_counter          = cerr_q;
    cerr_over_thres_fault = (state_q == OVER);
    IRQ_C                 = irqC_q;
    IRQ_UC                = irqUc_q;
    fault_mission_fault   = mission_q;
    fault_latent_fault    = latent_q;
  end

endmodule
